id_ex_pipe_reg: RTL

- Decode-to-execute pipeline register for the 5-stage RV32I core.
- Sits directly downstream of the opcode control decoder and ALU decoder, and of the register file read and immediate extender.
- Captures the decode-stage control bundle and operands on each clock and presents them to the execute stage.
- Supports stall (hold), flush (bubble insertion), valid gating, and a saturating bubble counter for performance debug.

---
 rtl/id_ex_pipe_reg_if.sv | 69 ++++++
 rtl/id_ex_pipe_reg.sv | 120 ++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_reg_if
// Description : Decode-to-execute handshake bundle. Decode side is the master;
//               the pipeline register is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_pipe_reg_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             stall_e;
    logic             flush_e;
    logic             valid_d;
    logic             reg_write_d;
    logic [1:0]       result_src_d;
    logic             mem_write_d;
    logic             jump_d;
    logic             branch_d;
    logic             alu_src_d;
    logic [2:0]       alu_control_d;
    logic [2:0]       funct3_d;
    logic [XLEN-1:0]  rd1_d;
    logic [XLEN-1:0]  rd2_d;
    logic [XLEN-1:0]  pc_d;
    logic [XLEN-1:0]  pc_plus4_d;
    logic [XLEN-1:0]  imm_ext_d;
    logic [4:0]       rs1_d;
    logic [4:0]       rs2_d;
    logic [4:0]       rd_d;

    logic             valid_e;
    logic             reg_write_e;
    logic [1:0]       result_src_e;
    logic             mem_write_e;
    logic             jump_e;
    logic             branch_e;
    logic             alu_src_e;
    logic [2:0]       alu_control_e;
    logic [2:0]       funct3_e;
    logic [XLEN-1:0]  rd1_e;
    logic [XLEN-1:0]  rd2_e;
    logic [XLEN-1:0]  pc_e;
    logic [XLEN-1:0]  pc_plus4_e;
    logic [XLEN-1:0]  imm_ext_e;
    logic [4:0]       rs1_e;
    logic [4:0]       rs2_e;
    logic [4:0]       rd_e;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output stall_e, flush_e, valid_d, reg_write_d, result_src_d, mem_write_d,
               jump_d, branch_d, alu_src_d, alu_control_d, funct3_d, rd1_d, rd2_d,
               pc_d, pc_plus4_d, imm_ext_d, rs1_d, rs2_d, rd_d,
        input  valid_e, reg_write_e, result_src_e, mem_write_e, jump_e, branch_e,
               alu_src_e, alu_control_e, funct3_e, rd1_e, rd2_e, pc_e, pc_plus4_e,
               imm_ext_e, rs1_e, rs2_e, rd_e, bubble_cnt
    );

    modport slave (
        input  stall_e, flush_e, valid_d, reg_write_d, result_src_d, mem_write_d,
               jump_d, branch_d, alu_src_d, alu_control_d, funct3_d, rd1_d, rd2_d,
               pc_d, pc_plus4_d, imm_ext_d, rs1_d, rs2_d, rd_d,
        output valid_e, reg_write_e, result_src_e, mem_write_e, jump_e, branch_e,
               alu_src_e, alu_control_e, funct3_e, rd1_e, rd2_e, pc_e, pc_plus4_e,
               imm_ext_e, rs1_e, rs2_e, rd_e, bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_reg
// Description : ID/EX pipeline register with stall, flush-to-bubble, valid
//               gating of side-effecting controls and a saturating bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    id_ex_pipe_reg_if.slave bus
);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic             r_valid;
    logic             r_reg_write;
    logic [1:0]       r_result_src;
    logic             r_mem_write;
    logic             r_jump;
    logic             r_branch;
    logic             r_alu_src;
    logic [2:0]       r_alu_control;
    logic [2:0]       r_funct3;
    logic [XLEN-1:0]  r_rd1;
    logic [XLEN-1:0]  r_rd2;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_pc_plus4;
    logic [XLEN-1:0]  r_imm_ext;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_reg_write   <= 1'b0;
            r_result_src  <= '0;
            r_mem_write   <= 1'b0;
            r_jump        <= 1'b0;
            r_branch      <= 1'b0;
            r_alu_src     <= 1'b0;
            r_alu_control <= '0;
            r_funct3      <= '0;
            r_rd1         <= '0;
            r_rd2         <= '0;
            r_pc          <= '0;
            r_pc_plus4    <= '0;
            r_imm_ext     <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_bubble_cnt  <= '0;
        end else if (bus.flush_e) begin
            // Whole bundle zeroed so rd=0 can never match a forwarding compare
            r_valid       <= 1'b0;
            r_reg_write   <= 1'b0;
            r_result_src  <= '0;
            r_mem_write   <= 1'b0;
            r_jump        <= 1'b0;
            r_branch      <= 1'b0;
            r_alu_src     <= 1'b0;
            r_alu_control <= '0;
            r_funct3      <= '0;
            r_rd1         <= '0;
            r_rd2         <= '0;
            r_pc          <= '0;
            r_pc_plus4    <= '0;
            r_imm_ext     <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            if (r_bubble_cnt != c_cnt_max) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end else if (!bus.stall_e) begin
            // Side-effecting controls qualified by valid; data fields pass through
            r_valid       <= bus.valid_d;
            r_reg_write   <= bus.valid_d & bus.reg_write_d;
            r_mem_write   <= bus.valid_d & bus.mem_write_d;
            r_jump        <= bus.valid_d & bus.jump_d;
            r_branch      <= bus.valid_d & bus.branch_d;
            r_result_src  <= bus.result_src_d;
            r_alu_src     <= bus.alu_src_d;
            r_alu_control <= bus.alu_control_d;
            r_funct3      <= bus.funct3_d;
            r_rd1         <= bus.rd1_d;
            r_rd2         <= bus.rd2_d;
            r_pc          <= bus.pc_d;
            r_pc_plus4    <= bus.pc_plus4_d;
            r_imm_ext     <= bus.imm_ext_d;
            r_rs1         <= bus.rs1_d;
            r_rs2         <= bus.rs2_d;
            r_rd          <= bus.rd_d;
        end
    end

    assign bus.valid_e       = r_valid;
    assign bus.reg_write_e   = r_reg_write;
    assign bus.result_src_e  = r_result_src;
    assign bus.mem_write_e   = r_mem_write;
    assign bus.jump_e        = r_jump;
    assign bus.branch_e      = r_branch;
    assign bus.alu_src_e     = r_alu_src;
    assign bus.alu_control_e = r_alu_control;
    assign bus.funct3_e      = r_funct3;
    assign bus.rd1_e         = r_rd1;
    assign bus.rd2_e         = r_rd2;
    assign bus.pc_e          = r_pc;
    assign bus.pc_plus4_e    = r_pc_plus4;
    assign bus.imm_ext_e     = r_imm_ext;
    assign bus.rs1_e         = r_rs1;
    assign bus.rs2_e         = r_rs2;
    assign bus.rd_e          = r_rd;
    assign bus.bubble_cnt    = r_bubble_cnt;
endmodule
`default_nettype wire
